// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC six-step commutation sequencer.
// The gate vector is ordered {A,AA,B,BB,C,CC}; phases are encoded A=0, B=1, C=2.
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_DRIVE,
    ST_FAULT
  } state_e;

  typedef logic [5:0] gate_t;

  localparam int unsigned GATE_A  = 5;
  localparam int unsigned GATE_AA = 4;
  localparam int unsigned GATE_B  = 3;
  localparam int unsigned GATE_BB = 2;
  localparam int unsigned GATE_C  = 1;
  localparam int unsigned GATE_CC = 0;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2
  } phase_e;

  typedef struct packed {
    phase_e hi;
    phase_e lo;
  } step_t;

  localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
  localparam logic [2:0] HALL_ILLEGAL_7 = 3'b111;

  // Forward step table indexed by hall code {H3,H2,H1}; entries 0 and 7 are unused.
  localparam step_t STEP_TBL [8] = '{
    '{hi: PH_A, lo: PH_A},
    '{hi: PH_A, lo: PH_B},
    '{hi: PH_C, lo: PH_A},
    '{hi: PH_C, lo: PH_B},
    '{hi: PH_B, lo: PH_C},
    '{hi: PH_A, lo: PH_C},
    '{hi: PH_B, lo: PH_A},
    '{hi: PH_A, lo: PH_A}
  };

  function automatic logic hall_legal(input logic [2:0] c);
    return (c != HALL_ILLEGAL_0) && (c != HALL_ILLEGAL_7);
  endfunction

  // Reverse direction swaps which phase is switched high and which is held low.
  function automatic gate_t step_gates(input step_t s, input logic dir, input logic hs_on);
    phase_e hp;
    phase_e lp;
    gate_t  g;
    hp = dir ? s.lo : s.hi;
    lp = dir ? s.hi : s.lo;
    g  = '0;
    case (hp)
      PH_A:    g[GATE_A] = hs_on;
      PH_B:    g[GATE_B] = hs_on;
      default: g[GATE_C] = hs_on;
    endcase
    case (lp)
      PH_A:    g[GATE_AA] = 1'b1;
      PH_B:    g[GATE_BB] = 1'b1;
      default: g[GATE_CC] = 1'b1;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser plus stability counter for the three hall inputs.
// A code is accepted once the synchronised value has held for DEB_CYC cycles.
module hall_debounce #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] H,
  output logic [2:0] code,
  output logic       chg
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [2:0]    s1_q, s1_d;
  logic [2:0]    s2_q, s2_d;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q, chg_d;

  always_comb begin
    s1_d   = H;
    s2_d   = s1_q;
    prev_d = s2_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    // cnt_d is the number of consecutive cycles s2_q has shown its current value
    if (s2_q != prev_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q < CW'(DEB_CYC)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == CW'(DEB_CYC)) begin
      code_d = s2_q;
    end
    chg_d = (code_d != code_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      code_q <= '0;
      cnt_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      code_q <= code_d;
      cnt_q  <= cnt_d;
      chg_q  <= chg_d;
    end
  end

  assign code = code_q;
  assign chg  = chg_q;

endmodule

// File: rtl/bldc_comm_sequencer.sv
// Six-step BLDC commutation sequencer: hall debounce, dead-time insertion,
// high-side PWM gating and illegal-code / stall fault shutdown.
module bldc_comm_sequencer
  import bldc_pkg::*;
#(
  parameter int unsigned DEB_CYC   = 4,
  parameter int unsigned DEAD_CYC  = 8,
  parameter int unsigned STALL_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       H1,
  input  logic       H2,
  input  logic       H3,
  input  logic [3:0] W,
  input  logic       EN,
  input  logic       DIR,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       AA,
  output logic       BB,
  output logic       CC,
  output logic       FAULT,
  output logic       COMM_STB
);

  localparam int unsigned DW = $clog2(DEAD_CYC + 1);
  localparam int unsigned SW = $clog2(STALL_CYC + 1);

  logic [2:0] code;
  logic       chg;
  logic       code_ok;
  logic       dir_chg;

  state_e        state_q, state_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [3:0]    p_q, p_d;
  logic          dir_q, dir_d;
  gate_t         gates_q, gates_d;
  logic          fault_q, fault_d;

  hall_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_hall (
    .CLK  (CLK),
    .RST_N(RST_N),
    .H    ({H3, H2, H1}),
    .code (code),
    .chg  (chg)
  );

  assign code_ok = hall_legal(code);
  assign dir_chg = (DIR != dir_q);

  always_comb begin
    state_d = state_q;
    dead_d  = '0;
    stall_d = '0;
    p_d     = p_q + 4'd1;
    dir_d   = DIR;
    unique case (state_q)
      ST_IDLE: begin
        if (EN) begin
          state_d = code_ok ? ST_DEAD : ST_FAULT;
        end
      end
      ST_DEAD: begin
        if (!code_ok) begin
          state_d = ST_FAULT;
        end else if (chg || dir_chg) begin
          dead_d = '0;
        end else if (dead_q == DW'(DEAD_CYC - 1)) begin
          state_d = ST_DRIVE;
        end else begin
          dead_d = dead_q + DW'(1);
        end
      end
      ST_DRIVE: begin
        if (!code_ok) begin
          state_d = ST_FAULT;
        end else if (chg || dir_chg) begin
          state_d = ST_DEAD;
        end else if (stall_q == SW'(STALL_CYC - 1)) begin
          state_d = ST_FAULT;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!EN) begin
      state_d = ST_IDLE;
    end
    // Gates follow the next state so that leaving DRIVE blanks them on the same edge
    gates_d = '0;
    if (state_d == ST_DRIVE) begin
      gates_d = step_gates(STEP_TBL[code], dir_q, p_q < W);
    end
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      dead_q  <= '0;
      stall_q <= '0;
      p_q     <= '0;
      dir_q   <= 1'b0;
      gates_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      stall_q <= stall_d;
      p_q     <= p_d;
      dir_q   <= dir_d;
      gates_q <= gates_d;
      fault_q <= fault_d;
    end
  end

  assign A        = gates_q[GATE_A];
  assign AA       = gates_q[GATE_AA];
  assign B        = gates_q[GATE_B];
  assign BB       = gates_q[GATE_BB];
  assign C        = gates_q[GATE_C];
  assign CC       = gates_q[GATE_CC];
  assign FAULT    = fault_q;
  assign COMM_STB = chg;

endmodule
